// File: rtl/regfile_rename_pkg.sv
// ----------------------------------------------------------------------------
// regfile_rename_pkg
// Shared definitions for the register file / rename table slice.
//   - default widths for register index, data and ROB tag
//   - default number of source read ports
//   - ZERO_REG: index of the hardwired-zero register
//   - num_regs(): register count for a given index width
// Imported by regfile_rename_if, regfile_rename_read_port and regfile_rename.
// ----------------------------------------------------------------------------
package regfile_rename_pkg;

    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int ROB_TAG_WIDTH_DEF  = 4;
    localparam int NUM_RD_PORTS_DEF   = 2;
    localparam int ZERO_REG           = 0;

    function automatic int num_regs(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/regfile_rename_if.sv
// ----------------------------------------------------------------------------
// regfile_rename_if
// Bundle of the decode/issue, ROB commit and read-port signals of the
// register file / rename table.
//   master : decode/issue + ROB side (drives addresses, issue, commit, flush)
//   slave  : the register file (returns rs_data / rs_busy / rs_tag)
// Signals
//   rdy_in   0 = hold all state
//   rs_addr  packed read addresses, port p at [p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
//   rs_data  packed read values
//   rs_busy  per-port busy flag (value pending in ROB)
//   rs_tag   packed ROB tag of the pending producer
//   iss_*    rename of a destination register at issue
//   cmt_*    ROB commit with register write
//   flush_in mispredict, clears all renames
// ----------------------------------------------------------------------------
interface regfile_rename_if
    import regfile_rename_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ROB_TAG_WIDTH  = ROB_TAG_WIDTH_DEF,
    parameter int NUM_RD_PORTS   = NUM_RD_PORTS_DEF
);

    logic                                     rdy_in;
    logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0]   rs_addr;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0]       rs_data;
    logic [NUM_RD_PORTS-1:0]                  rs_busy;
    logic [NUM_RD_PORTS*ROB_TAG_WIDTH-1:0]    rs_tag;
    logic                                     iss_en;
    logic [REG_ADDR_WIDTH-1:0]                iss_rd;
    logic [ROB_TAG_WIDTH-1:0]                 iss_tag;
    logic                                     cmt_en;
    logic [REG_ADDR_WIDTH-1:0]                cmt_rd;
    logic [ROB_TAG_WIDTH-1:0]                 cmt_tag;
    logic [DATA_WIDTH-1:0]                    cmt_data;
    logic                                     flush_in;

    modport master (
        output rdy_in, rs_addr,
        output iss_en, iss_rd, iss_tag,
        output cmt_en, cmt_rd, cmt_tag, cmt_data,
        output flush_in,
        input  rs_data, rs_busy, rs_tag
    );

    modport slave (
        input  rdy_in, rs_addr,
        input  iss_en, iss_rd, iss_tag,
        input  cmt_en, cmt_rd, cmt_tag, cmt_data,
        input  flush_in,
        output rs_data, rs_busy, rs_tag
    );

endinterface

// File: rtl/regfile_rename_read_port.sv
// ----------------------------------------------------------------------------
// regfile_rename_read_port
// One source read port of the register file / rename table. Selects the
// addressed entry from the registered data/busy/tag arrays, forces x0 to
// zero / not busy / tag 0, and (optionally) forwards a same-cycle commit.
// Ports
//   rst_in, rdy_in            qualify the commit bypass
//   cmt_en/rd/tag/data        commit currently presented to the register file
//   data_arr/busy_arr/tag_arr registered state of all registers
//   rd_addr                   source register index
//   rd_data/rd_busy/rd_tag    read result
// Configuration
//   REGFILE_BYPASS_EN defined: a commit to rd_addr in the same cycle is
//   forwarded (data from the commit, busy cleared when the stored tag
//   matches the committing tag). Undefined: registered state only.
// ----------------------------------------------------------------------------
module regfile_rename_read_port
    import regfile_rename_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ROB_TAG_WIDTH  = ROB_TAG_WIDTH_DEF
) (
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      cmt_en,
    input  logic [REG_ADDR_WIDTH-1:0] cmt_rd,
    input  logic [ROB_TAG_WIDTH-1:0]  cmt_tag,
    input  logic [DATA_WIDTH-1:0]     cmt_data,
    input  logic [DATA_WIDTH-1:0]     data_arr [num_regs(REG_ADDR_WIDTH)],
    input  logic [num_regs(REG_ADDR_WIDTH)-1:0] busy_arr,
    input  logic [ROB_TAG_WIDTH-1:0]  tag_arr  [num_regs(REG_ADDR_WIDTH)],
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_busy,
    output logic [ROB_TAG_WIDTH-1:0]  rd_tag
);

    localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(ZERO_REG);

    logic byp_hit;

`ifdef REGFILE_BYPASS_EN
    // Forwarding is only legal when the commit will really land this edge.
    assign byp_hit = cmt_en && rdy_in && !rst_in && (cmt_rd == rd_addr);
`else
    logic unused_bypass;
    assign byp_hit       = 1'b0;
    assign unused_bypass = ^{rst_in, rdy_in, cmt_en, cmt_rd, cmt_tag, cmt_data};
`endif

    always_comb begin
        rd_data = data_arr[rd_addr];
        rd_busy = busy_arr[rd_addr];
        rd_tag  = tag_arr[rd_addr];
        if (byp_hit) begin
            rd_data = cmt_data;
            // Only the producer the rename table is waiting on clears busy;
            // a stale commit still delivers data but the newer rename stays.
            if (tag_arr[rd_addr] == cmt_tag) begin
                rd_busy = 1'b0;
            end
        end
        // x0 overrides everything, including the bypass.
        if (rd_addr == X0) begin
            rd_data = '0;
            rd_busy = 1'b0;
            rd_tag  = '0;
        end
    end

endmodule

// File: rtl/regfile_rename.sv
// ----------------------------------------------------------------------------
// regfile_rename
// Architectural register file plus rename table for the Tomasulo core,
// between decode/issue and ROB commit. Each register holds a value, a busy
// bit (value pending in the ROB) and the ROB tag of the pending producer.
// Ports
//   clk_in   system clock
//   rst_in   synchronous active-high reset (clears data, busy and tag)
//   rf       regfile_rename_if.slave: rdy_in stall, NUM_RD_PORTS read ports,
//            issue (iss_*), commit (cmt_*) and flush_in
// Write priority per edge: reset > stall (rdy_in=0) > commit/flush/issue.
// Within an active edge the commit is applied first, then flush clears all
// busy bits, otherwise the issue rename overwrites busy/tag (younger wins).
// Configuration
//   REGFILE_BYPASS_EN  enables same-cycle commit-to-read forwarding inside
//                      regfile_rename_read_port; default build reads
//                      registered state only.
// ----------------------------------------------------------------------------
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ROB_TAG_WIDTH  = ROB_TAG_WIDTH_DEF,
    parameter int NUM_RD_PORTS   = NUM_RD_PORTS_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    regfile_rename_if.slave  rf
);

    localparam int NUM_REGS = num_regs(REG_ADDR_WIDTH);
    localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0]    data_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]    data_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q;
    logic [NUM_REGS-1:0]      busy_d;
    logic [ROB_TAG_WIDTH-1:0] tag_q  [NUM_REGS];
    logic [ROB_TAG_WIDTH-1:0] tag_d  [NUM_REGS];

    logic cmt_wr;
    logic iss_wr;

    assign cmt_wr = rf.cmt_en && (rf.cmt_rd != X0);
    assign iss_wr = rf.iss_en && (rf.iss_rd != X0);

    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rf.rdy_in) begin
            if (cmt_wr) begin
                data_d[rf.cmt_rd] = rf.cmt_data;
                if (busy_q[rf.cmt_rd] && (tag_q[rf.cmt_rd] == rf.cmt_tag)) begin
                    busy_d[rf.cmt_rd] = 1'b0;
                end
            end
            if (rf.flush_in) begin
                // The issuing instruction is on the squashed path, drop it.
                busy_d = '0;
            end else if (iss_wr) begin
                busy_d[rf.iss_rd] = 1'b1;
                tag_d[rf.iss_rd]  = rf.iss_tag;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    logic [DATA_WIDTH-1:0]    rd_data_w [NUM_RD_PORTS];
    logic [NUM_RD_PORTS-1:0]  rd_busy_w;
    logic [ROB_TAG_WIDTH-1:0] rd_tag_w  [NUM_RD_PORTS];

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        regfile_rename_read_port #(
            .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
            .DATA_WIDTH     (DATA_WIDTH),
            .ROB_TAG_WIDTH  (ROB_TAG_WIDTH)
        ) u_rd_port (
            .rst_in   (rst_in),
            .rdy_in   (rf.rdy_in),
            .cmt_en   (rf.cmt_en),
            .cmt_rd   (rf.cmt_rd),
            .cmt_tag  (rf.cmt_tag),
            .cmt_data (rf.cmt_data),
            .data_arr (data_q),
            .busy_arr (busy_q),
            .tag_arr  (tag_q),
            .rd_addr  (rf.rs_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
            .rd_data  (rd_data_w[p]),
            .rd_busy  (rd_busy_w[p]),
            .rd_tag   (rd_tag_w[p])
        );
    end

    always_comb begin
        rf.rs_data = '0;
        rf.rs_tag  = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rf.rs_data[p*DATA_WIDTH +: DATA_WIDTH]       = rd_data_w[p];
            rf.rs_tag[p*ROB_TAG_WIDTH +: ROB_TAG_WIDTH]  = rd_tag_w[p];
        end
    end

    assign rf.rs_busy = rd_busy_w;

endmodule
